// File: rtl/mgmt_rx_frame_reader.sv
// rtl/mgmt_rx_frame_reader.sv - RX frame reader: length/data FIFO to byte-wide read port
//
// Purpose: takes one frame length from the upstream length FIFO, prefetches the
// first data word, then hands the frame out one byte per read request. The next
// data word is popped as the last byte of the current word is read. A pop request
// discards the frame and drains any words that were not yet popped.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   len_fifo_empty   upstream length FIFO empty
//   len_fifo_rd      pop length FIFO (data valid on len_fifo_rdata next cycle)
//   len_fifo_rdata   frame length in bytes
//   data_fifo_rd     pop data FIFO (data valid on data_fifo_rdata next cycle)
//   data_fifo_rdata  32-bit data word, byte 0 in bits 31:24
//   frame_ready      frame loaded and readable
//   frame_len        byte length of loaded frame
//   byte_rd_en       request next byte
//   byte_rd_valid    byte_rd_data valid (one cycle after byte_rd_en)
//   byte_rd_data     returned byte
//   pop              discard current frame

module mgmt_rx_frame_reader #(
    parameter int LEN_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 len_fifo_empty,
    output logic                 len_fifo_rd,
    input  logic [LEN_WIDTH-1:0] len_fifo_rdata,
    output logic                 data_fifo_rd,
    input  logic [31:0]          data_fifo_rdata,
    output logic                 frame_ready,
    output logic [LEN_WIDTH-1:0] frame_len,
    input  logic                 byte_rd_en,
    output logic                 byte_rd_valid,
    output logic [7:0]           byte_rd_data,
    input  logic                 pop
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_WAIT,
        PREFETCH,
        READY,
        DISCARD
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [LEN_WIDTH-1:0] r_frame_len;
    logic [LEN_WIDTH-1:0] r_words;
    logic [LEN_WIDTH-1:0] r_words_popped;
    logic [LEN_WIDTH-1:0] r_byte_idx;
    logic [31:0]          r_buf;
    logic                 r_land;
    logic                 r_rd_valid;
    logic [7:0]           r_rd_data;

    logic                 w_len_rd;
    logic                 w_data_rd;
    logic                 w_rd_ok;
    logic [LEN_WIDTH-1:0] w_words_calc;
    logic [LEN_WIDTH-1:0] w_popped_next;
    logic [31:0]          w_word;
    logic [7:0]           w_byte;

    assign w_words_calc = LEN_WIDTH'((32'(len_fifo_rdata) + 32'd3) >> 2);

    // Only in-range reads in READY consume a byte; the compare also keeps
    // byte_idx from ever wrapping.
    assign w_rd_ok = byte_rd_en && (r_state == READY) && (r_byte_idx < r_frame_len);

    // A word counts as popped in the cycle data_fifo_rd is asserted, so a word
    // still in flight is never requested a second time.
    assign w_data_rd = ((r_state == LEN_WAIT) && (len_fifo_rdata != '0))
                     || ((r_state == READY) && w_rd_ok && (r_byte_idx[1:0] == 2'd3)
                         && (r_words_popped < r_words))
                     || ((r_state == DISCARD) && (r_words_popped < r_words));

    assign w_popped_next = r_words_popped + LEN_WIDTH'(w_data_rd);

    // A word popped last cycle is only on data_fifo_rdata this cycle; read it
    // directly so back-to-back reads never stall.
    assign w_word = r_land ? data_fifo_rdata : r_buf;

    always_comb begin
        w_byte = 8'h00;
        case (r_byte_idx[1:0])
            2'd0:    w_byte = w_word[31:24];
            2'd1:    w_byte = w_word[23:16];
            2'd2:    w_byte = w_word[15:8];
            default: w_byte = w_word[7:0];
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_len_rd = 1'b0;
        case (r_state)
            IDLE: begin
                if (!len_fifo_empty) begin
                    w_len_rd = 1'b1;
                    w_next   = LEN_WAIT;
                end
            end
            LEN_WAIT: begin
                w_next = (len_fifo_rdata == '0) ? READY : PREFETCH;
            end
            PREFETCH: begin
                w_next = READY;
            end
            READY: begin
                if (pop) begin
                    w_next = (w_popped_next == r_words) ? IDLE : DISCARD;
                end
            end
            DISCARD: begin
                if (w_popped_next == r_words) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_frame_len    <= '0;
            r_words        <= '0;
            r_words_popped <= '0;
            r_byte_idx     <= '0;
            r_buf          <= '0;
            r_land         <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_data      <= 8'h00;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= byte_rd_en;
            r_rd_data  <= w_rd_ok ? w_byte : 8'h00;
            r_land     <= w_data_rd;
            if (r_land) begin
                r_buf <= data_fifo_rdata;
            end
            if (r_state == LEN_WAIT) begin
                r_frame_len <= len_fifo_rdata;
                r_words     <= w_words_calc;
            end
            if ((w_next == IDLE) && (r_state != IDLE)) begin
                r_byte_idx     <= '0;
                r_words_popped <= '0;
            end else begin
                if (w_rd_ok) begin
                    r_byte_idx <= r_byte_idx + 1'b1;
                end
                r_words_popped <= w_popped_next;
            end
        end
    end

    // The length pop is gated by reset so every output reads 0 while rst_n is low.
    assign len_fifo_rd   = w_len_rd && rst_n;
    assign data_fifo_rd  = w_data_rd;
    assign frame_ready   = (r_state == READY);
    assign frame_len     = r_frame_len;
    assign byte_rd_valid = r_rd_valid;
    assign byte_rd_data  = r_rd_data;

endmodule

// File: doc/mgmt_rx_frame_reader.md
MGMT_RX_FRAME_READER -- requirements
Module: mgmt_rx_frame_reader

Interface
REQ-001 The block SHALL have exactly one parameter: LEN_WIDTH, default 11, width of the frame byte-length field (frames up to 2047 bytes).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset; all logic is clocked on its rising edge.
REQ-003 clk  in  1  management core clock (sys_clk domain); the only clock.
REQ-004 rst_n  in  1  asynchronous reset, active low.
REQ-005 len_fifo_empty  in  1  upstream RX length FIFO is empty.
REQ-006 len_fifo_rd  out  1  pops one length entry; data appears on len_fifo_rdata the next cycle.
REQ-007 len_fifo_rdata  in  LEN_WIDTH  frame length in bytes.
REQ-008 data_fifo_rd  out  1  pops one 32-bit word; data appears on data_fifo_rdata the next cycle.
REQ-009 data_fifo_rdata  in  32  frame data word; byte 0 is in bits 31:24 (network order).
REQ-010 frame_ready  out  1  a frame is loaded and readable; register-interface IRQ source.
REQ-011 frame_len  out  LEN_WIDTH  byte length of the loaded frame.
REQ-012 byte_rd_en  in  1  one-cycle request for the next frame byte.
REQ-013 byte_rd_valid  out  1  byte_rd_data is valid this cycle.
REQ-014 byte_rd_data  out  8  returned byte.
REQ-015 pop  in  1  one-cycle request to discard the current frame, including any unread remainder.

Function
REQ-016 The FSM SHALL have the states IDLE, LEN_WAIT, PREFETCH, READY and DISCARD.
REQ-017 In IDLE with len_fifo_empty=0, the block SHALL assert len_fifo_rd for one cycle and go to LEN_WAIT.
REQ-018 LEN_WAIT SHALL latch frame_len and words=(len+3)>>2.
  - len=0: go to READY.
  - len>0: assert data_fifo_rd and go to PREFETCH.
REQ-019 PREFETCH SHALL latch data_fifo_rdata into the word buffer, set words_popped=1 and go to READY.
REQ-020 frame_ready SHALL be 1 exactly while in READY.
  - Latency from len_fifo_empty falling in IDLE to frame_ready: 3 cycles for len>0, 2 cycles for len=0.
REQ-021 A byte read in READY with byte_idx<frame_len SHALL behave as follows.
  - Return byte (byte_idx mod 4) of the buffer.
  - Increment byte_idx.
  - If byte_idx[1:0]==3 and words_popped<words, assert data_fifo_rd in the same cycle.
REQ-022 The word popped by REQ-021 SHALL be loaded into the buffer the next cycle; a read in that same cycle SHALL take its byte from data_fifo_rdata (bypass).
REQ-023 byte_rd_valid SHALL assert 1 cycle after every byte_rd_en, in every state; back-to-back reads every cycle SHALL be supported.
REQ-024 Reads with byte_idx>=frame_len, or reads outside READY, SHALL return 0x00, not increment byte_idx, and not pop the data FIFO.
REQ-025 pop in READY SHALL be handled as follows; pop in any other state SHALL be ignored.
  - words_popped==words: go to IDLE next cycle.
  - Otherwise: go to DISCARD.
REQ-026 DISCARD SHALL assert data_fifo_rd once per cycle until words_popped==words, then go to IDLE; byte_idx SHALL be cleared on entry to IDLE.
REQ-027 A word popped but not yet landed counts as popped; it SHALL NOT be popped twice.
REQ-028 byte_rd_en and pop in the same cycle: the read SHALL be serviced from current data (including a bypass word), then the discard proceeds.
REQ-029 words_popped and byte_idx SHALL be LEN_WIDTH bits wide and SHALL never wrap.
REQ-030 The block SHALL NOT pop the length FIFO again before returning to IDLE.

Reset
REQ-031 On rst_n=0 the block SHALL asynchronously enter IDLE, drive every output to 0, and clear the buffer and counters.
REQ-032 A reset mid-frame SHALL abandon the frame without draining it; upstream FIFOs SHALL share rst_n.

Verification
REQ-033 len=6, words 0xDEADBEEF,0x01020000; 8 reads -> DE AD BE EF 01 02 00 00; exactly 2 data pops; valid 1 cycle after each read.
REQ-034 len=5, 5 back-to-back reads -> byte 5 arrives via bypass the cycle after the 2nd pop; no stall, no third pop.
REQ-035 len=12, 2 bytes read, then pop -> DISCARD pops 2 more words in consecutive cycles; IDLE after; total pops=3.
REQ-036 len=0 -> frame_ready at cycle 2, no data pops; a read returns 0x00; pop -> IDLE next cycle.
REQ-037 Two frames queued -> the second len_fifo_rd occurs only after the first pop; frame_len updates to the second length.
REQ-038 rst_n low during READY with data pending -> all outputs 0 immediately; after release, IDLE and no spurious FIFO pops.
